dmem_responder: RTL and testbench

Responder side of the Memory-stage data-memory interface. It accepts the stage's write-enable, address and store data, plus the load/store width (funct3). It returns width-selected, sign- or zero-extended load data. The block owns the byte-lane storage array and clears it to zero after reset with a sequential init engine. It also detects misaligned and illegal-width accesses and latches the first one for later inspection.

---
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage: byte-lane array with a sequential
// zero-fill engine, width-selected loads and a sticky first-fault latch.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic        RE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic [2:0]  Funct3,
    output logic [31:0] RD,
    output logic        Busy,
    output logic        Fault,
    output logic        ErrValid,
    output logic [31:0] ErrAddr,
    input  logic        ErrClr
);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH_WORDS - 1);

    state_t          state;
    logic [AW:0]     clrCnt;
    logic [3:0][7:0] mem [DEPTH_WORDS];

    logic [AW-1:0]   wordIdx;
    logic [1:0]      byteOff;
    logic            isHalf;
    logic            isWord;
    logic            loadLegal;
    logic            storeLegal;
    logic            misaligned;
    logic            storeGo;
    logic            loadGo;

    logic [3:0]      storeLanes;
    logic [3:0][7:0] storeData;

    logic            wrEn;
    logic [AW-1:0]   wrIdx;
    logic [3:0]      wrLanes;
    logic [3:0][7:0] wrData;

    logic [3:0][7:0] rdWord;
    logic [7:0]      rdByte;
    logic [15:0]     rdHalf;

    assign wordIdx = A[AW+1:2];
    assign byteOff = A[1:0];
    assign Busy    = (state == INIT);

    // Access classification; stores accept only the three signed encodings.
    always_comb begin
        isHalf     = (Funct3[1:0] == 2'b01);
        isWord     = (Funct3[1:0] == 2'b10);
        loadLegal  = (Funct3 != 3'b011) && (Funct3 != 3'b110) && (Funct3 != 3'b111);
        storeLegal = !Funct3[2] && (Funct3[1:0] != 2'b11);
        misaligned = (isHalf && A[0]) || (isWord && (A[1:0] != 2'b00));
        Fault      = !Busy && ((WE && (!storeLegal || misaligned)) ||
                               (RE && (!loadLegal || misaligned)));
        storeGo    = WE && !Busy && !Fault;
        loadGo     = RE && !Busy && !Fault;
    end

    // Store data is replicated across lanes so the lane enables alone pick the target.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        storeLanes = 4'b0000;
        storeData  = WD;
        case (Funct3[1:0])
            2'b00: begin
                storeLanes = 4'b0001 << byteOff;
                storeData  = {4{WD[7:0]}};
            end
            2'b01: begin
                storeLanes = A[1] ? 4'b1100 : 4'b0011;
                storeData  = {2{WD[15:0]}};
            end
            default: begin
                storeLanes = 4'b1111;
                storeData  = WD;
            end
        endcase
    end

    // The init engine owns the single write port while Busy; a reset edge writes nothing.
    always_comb begin
        wrEn    = 1'b0;
        wrIdx   = wordIdx;
        wrLanes = storeLanes;
        wrData  = storeData;
        if (Busy) begin
            wrEn    = !rst;
            wrIdx   = clrCnt[AW-1:0];
            wrLanes = 4'b1111;
            wrData  = '0;
        end else begin
            wrEn = storeGo && !rst;
        end
    end

    // NOTE: the array has no reset; it is cleared by the init engine so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (wrLanes[i]) begin
                    mem[wrIdx][i] <= wrData[i];
                end
            end
        end
    end

    always_comb begin
        rdWord = mem[wordIdx];
        rdByte = rdWord[byteOff];
        rdHalf = A[1] ? rdWord[3:2] : rdWord[1:0];
        RD     = '0;
        if (loadGo) begin
            case (Funct3)
                3'b000:  RD = {{24{rdByte[7]}}, rdByte};
                3'b100:  RD = {24'b0, rdByte};
                3'b001:  RD = {{16{rdHalf[15]}}, rdHalf};
                3'b101:  RD = {16'b0, rdHalf};
                3'b010:  RD = rdWord;
                default: RD = '0;
            endcase
        end
    end

    // Control FSM and first-fault latch; a fault arriving with ErrClr wins over the clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (rst) begin
            state    <= INIT;
            clrCnt   <= '0;
            ErrValid <= 1'b0;
            ErrAddr  <= '0;
        end else begin
            case (state)
                INIT: begin
                    clrCnt <= clrCnt + 1'b1;
                    if (clrCnt == LAST_IDX) begin
                        state <= READY;
                    end
                end
                default: state <= READY;
            endcase

            if (Fault) begin
                if (!ErrValid || ErrClr) begin
                    ErrValid <= 1'b1;
                    ErrAddr  <= A;
                end
            end else if (ErrClr) begin
                ErrValid <= 1'b0;
                ErrAddr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expectations queued at stimulus time,
// popped and compared by immediate assertions when the output is sampled.
module tb_dmem_responder;

    localparam int DW = 16;
    localparam int AWW = 4;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WE = 1'b0;
    logic        RE = 1'b0;
    logic        ErrClr = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] RD;
    logic [31:0] ErrAddr;
    logic        Busy;
    logic        Fault;
    logic        ErrValid;

    int          total = 0;
    int          bad = 0;
    string       tagQ[$];
    logic [31:0] expQ[$];

    always #50 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DW), .AW(AWW)) dut (
        .clk      (clk),
        .rst      (rst),
        .WE       (WE),
        .RE       (RE),
        .A        (A),
        .WD       (WD),
        .Funct3   (Funct3),
        .RD       (RD),
        .Busy     (Busy),
        .Fault    (Fault),
        .ErrValid (ErrValid),
        .ErrAddr  (ErrAddr),
        .ErrClr   (ErrClr)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        WE     = we;
        RE     = re;
        Funct3 = f3;
        A      = a;
        WD     = wd;
        #1;
    endtask

    task automatic want(input string t, input logic [31:0] e);
        tagQ.push_back(t);
        expQ.push_back(e);
    endtask

    task automatic see(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
        end else begin
            t = tagQ.pop_front();
            e = expQ.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    initial begin
        int n;

        tick();
        tick();
        rst = 1'b0;

        want("rst_busy", 32'd1);        see({31'b0, Busy});
        want("rst_errvalid", 32'd0);    see({31'b0, ErrValid});
        want("rst_erraddr", 32'd0);     see(ErrAddr);
        want("rst_fault", 32'd0);       see({31'b0, Fault});
        want("rst_rd", 32'd0);          see(RD);

        // Misaligned access while Busy must neither fault nor return data.
        drive(1'b1, 1'b1, F_W, 32'h5, 32'hDEADBEEF);
        want("busy_fault", 32'd0);      see({31'b0, Fault});
        want("busy_rd", 32'd0);         see(RD);
        A = 32'h4;

        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        want("init_busy_cycles", 32'd16); see(n);

        for (int i = 0; i < DW; i++) begin
            drive(1'b0, 1'b1, F_W, 32'(i * 4), 32'h0);
            want($sformatf("scan_lw_%0h", i * 4), 32'h0); see(RD);
            tick();
        end
        want("post_init_errvalid", 32'd0); see({31'b0, ErrValid});

        drive(1'b1, 1'b0, F_W, 32'h8, 32'h80FF7F01);
        tick();
        drive(1'b0, 1'b1, F_B,  32'h8, 32'h0); want("lb_8", 32'h00000001);   see(RD);
        drive(1'b0, 1'b1, F_B,  32'hB, 32'h0); want("lb_b", 32'hFFFFFF80);   see(RD);
        drive(1'b0, 1'b1, F_BU, 32'hB, 32'h0); want("lbu_b", 32'h00000080);  see(RD);
        drive(1'b0, 1'b1, F_H,  32'hA, 32'h0); want("lh_a", 32'hFFFF80FF);   see(RD);
        drive(1'b0, 1'b1, F_HU, 32'hA, 32'h0); want("lhu_a", 32'h000080FF);  see(RD);
        drive(1'b0, 1'b1, F_W,  32'h8, 32'h0); want("lw_8", 32'h80FF7F01);   see(RD);
        drive(1'b0, 1'b0, F_W,  32'h8, 32'h0); want("rd_idle", 32'h0);       see(RD);

        drive(1'b1, 1'b1, F_W, 32'hC, 32'h11223344);
        want("we_re_prewrite", 32'h0); see(RD);
        tick();
        drive(1'b0, 1'b1, F_W, 32'hC, 32'h0); want("we_re_after", 32'h11223344); see(RD);

        drive(1'b1, 1'b0, F_B, 32'h9, 32'h555555AA);
        tick();
        drive(1'b0, 1'b1, F_W, 32'h8, 32'h0); want("sb_9", 32'h80FFAA01); see(RD);
        drive(1'b1, 1'b0, F_H, 32'h48, 32'hABCD1234);
        tick();
        drive(1'b0, 1'b1, F_W, 32'h8, 32'h0); want("sh_alias_48", 32'h80FF1234); see(RD);

        drive(1'b1, 1'b0, F_W, 32'h6, 32'hFFFFFFFF);
        want("sw_6_fault", 32'd1); see({31'b0, Fault});
        tick();
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        want("sw_6_errvalid", 32'd1); see({31'b0, ErrValid});
        want("sw_6_erraddr", 32'h6);  see(ErrAddr);
        drive(1'b0, 1'b1, F_W, 32'h4, 32'h0); want("sw_6_dropped", 32'h0); see(RD);

        drive(1'b0, 1'b1, F_H, 32'h11, 32'h0);
        want("lh_11_fault", 32'd1); see({31'b0, Fault});
        want("lh_11_rd", 32'h0);    see(RD);
        tick();
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        want("lh_11_errvalid", 32'd1); see({31'b0, ErrValid});
        want("lh_11_erraddr_kept", 32'h6); see(ErrAddr);

        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        #1;
        want("clr_errvalid", 32'd0); see({31'b0, ErrValid});
        want("clr_erraddr", 32'h0);  see(ErrAddr);

        drive(1'b1, 1'b0, F_BU, 32'h10, 32'h0);
        want("store_f3_100_fault", 32'd1); see({31'b0, Fault});
        drive(1'b0, 1'b1, F_BU, 32'h10, 32'h0);
        want("load_f3_100_ok", 32'd0); see({31'b0, Fault});
        drive(1'b0, 1'b1, 3'b011, 32'h8, 32'h0);
        want("f3_011_fault", 32'd1); see({31'b0, Fault});
        want("f3_011_rd", 32'h0);    see(RD);
        tick();
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        want("f3_011_erraddr", 32'h8); see(ErrAddr);

        drive(1'b0, 1'b1, F_W, 32'h3, 32'h0);
        ErrClr = 1'b1;
        #1;
        want("clr_fault_same_fault", 32'd1); see({31'b0, Fault});
        tick();
        ErrClr = 1'b0;
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        want("clr_fault_errvalid", 32'd1); see({31'b0, ErrValid});
        want("clr_fault_erraddr", 32'h3);  see(ErrAddr);

        drive(1'b1, 1'b0, F_W, 32'h10, 32'hCAFEF00D);
        tick();
        drive(1'b0, 1'b1, F_W, 32'h10, 32'h0); want("lw_10_pre_rst", 32'hCAFEF00D); see(RD);

        // Reset from READY, then again in init cycle 7.
        drive(1'b1, 1'b0, F_W, 32'h14, 32'h00000001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        want("rst2_errvalid", 32'd0); see({31'b0, ErrValid});
        want("rst2_erraddr", 32'h0);  see(ErrAddr);
        want("rst2_busy", 32'd1);     see({31'b0, Busy});
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        want("midinit_busy_cycles", 32'd16); see(n);
        want("midinit_errvalid", 32'd0);     see({31'b0, ErrValid});
        drive(1'b0, 1'b1, F_W, 32'h10, 32'h0); want("midinit_lw_10", 32'h0); see(RD);
        drive(1'b0, 1'b1, F_W, 32'h8, 32'h0);  want("midinit_lw_8", 32'h0);  see(RD);
        drive(1'b0, 1'b1, F_W, 32'hC, 32'h0);  want("midinit_lw_c", 32'h0);  see(RD);
        drive(1'b0, 1'b1, F_W, 32'h14, 32'h0); want("midinit_lw_14", 32'h0); see(RD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
